// File: rtl/data_distributor_1to4.sv
// Registered 1-to-4 data distributor: one-entry holding register and valid/ready per channel.
// Optional per-channel drain counters enabled by defining DATA_DISTRIBUTOR_COUNT_EN.
module data_distributor_1to4 #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_c,
   output logic [WIDTH-1:0] out_d,
   output logic             busy
`ifdef DATA_DISTRIBUTOR_COUNT_EN
   ,
   output logic [63:0]      drain_count
`endif
);

   logic [3:0]       full_q, full_d;
   logic [WIDTH-1:0] data_q [4];
   logic [WIDTH-1:0] data_d [4];
   logic [3:0]       load, drain;
   logic             accept;

   // Only the addressed channel can block the producer.
   assign in_ready = ~full_q[in_sel] | out_ready[in_sel];
   assign accept   = in_valid & in_ready;
   assign drain    = full_q & out_ready;

   always_comb begin
      load   = '0;
      full_d = full_q;
      for (int k = 0; k < 4; k++) begin
         data_d[k] = data_q[k];
         load[k]   = accept && (in_sel == 2'(k));
         full_d[k] = load[k] | (full_q[k] & ~drain[k]);
         if (load[k]) data_d[k] = in_data;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         full_q <= '0;
         for (int k = 0; k < 4; k++) data_q[k] <= '0;
      end else begin
         full_q <= full_d;
         for (int k = 0; k < 4; k++) data_q[k] <= data_d[k];
      end
   end

   assign out_valid = full_q;
   assign out_a     = data_q[0];
   assign out_b     = data_q[1];
   assign out_c     = data_q[2];
   assign out_d     = data_q[3];
   assign busy      = |full_q;

`ifdef DATA_DISTRIBUTOR_COUNT_EN
   logic [15:0] cnt_q [4];
   logic [15:0] cnt_d [4];

   // Free-running drain counters; wrap naturally at 16 bits.
   always_comb begin
      for (int k = 0; k < 4; k++)
         cnt_d[k] = drain[k] ? cnt_q[k] + 16'd1 : cnt_q[k];
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
      end
   end

   always_comb begin
      drain_count = '0;
      for (int k = 0; k < 4; k++) drain_count[16*k +: 16] = cnt_q[k];
   end
`endif

endmodule

// File: tb/tb_data_distributor_1to4.sv
// Directed self-checking bench for data_distributor_1to4 (counter checks only with DATA_DISTRIBUTOR_COUNT_EN).
module tb_data_distributor_1to4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_sel;
   logic [31:0] in_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_a, out_b, out_c, out_d;
   logic        busy;
`ifdef DATA_DISTRIBUTOR_COUNT_EN
   logic [63:0] drain_count;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int aa_drains = 0;
   logic [31:0] d_seen [$];
   int          d_cyc  [$];

   data_distributor_1to4 #(.WIDTH(32)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_c(out_c),
      .out_d(out_d), .busy(busy)
`ifdef DATA_DISTRIBUTOR_COUNT_EN
      , .drain_count(drain_count)
`endif
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (RST && out_valid[0] && out_ready[0] && out_a == 32'hAA) aa_drains <= aa_drains + 1;
      if (RST && out_valid[3] && out_ready[3]) begin
         d_seen.push_back(out_d);
         d_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = '0;
      #2;
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1 chk("rst_in_ready", 64'(in_ready), 64'h1);
      end
      step();
      RST = 1'b1;
      in_sel = 2'd1;
      #1 chk("post_rst_in_ready", 64'(in_ready), 64'h1);

      // Single delivery to C, consumer stalled
      in_sel = 2'd2; in_data = 32'hDEADBEEF; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("single_valid", 64'(out_valid), 64'h4);
      chk("single_data", 64'(out_c), 64'hDEADBEEF);
      step(); step();
      chk("single_hold_valid", 64'(out_valid), 64'h4);
      chk("single_hold_data", 64'(out_c), 64'hDEADBEEF);
      chk("single_busy", 64'(busy), 64'h1);
      out_ready = 4'b0100;
      step();
      out_ready = 4'b0000;
      chk("drain_c_valid", 64'(out_valid), 64'h0);
      chk("drain_c_data_kept", 64'(out_c), 64'hDEADBEEF);

      // Backpressure isolation: A full and stalled
      in_sel = 2'd0; in_data = 32'hAA; in_valid = 1'b1;
      step();
      in_data = 32'hCC;
      #1 chk("bp_sel0_ready", 64'(in_ready), 64'h0);
      in_sel = 2'd1; in_data = 32'h1;
      #1 chk("bp_sel1_ready", 64'(in_ready), 64'h1);
      step();
      in_valid = 1'b0;
      chk("bp_out_b", 64'(out_b), 64'h1);
      chk("bp_valid", 64'(out_valid), 64'h3);
      chk("bp_out_a", 64'(out_a), 64'hAA);

      // Stall recovery plus simultaneous accept/drain on A, B drained alongside
      in_sel = 2'd0; in_data = 32'hBB; in_valid = 1'b1; out_ready = 4'b0011;
      #1 chk("recover_ready", 64'(in_ready), 64'h1);
      step();
      in_valid = 1'b0; out_ready = 4'b0000;
      chk("sim_out_a", 64'(out_a), 64'hBB);
      chk("sim_valid", 64'(out_valid), 64'h1);
      out_ready = 4'b0001;
      step();
      out_ready = 4'b0000;
      chk("sim_aa_once", 64'(aa_drains), 64'h1);
      chk("sim_empty", 64'(out_valid), 64'h0);

      // Streaming 0..7 into D
      out_ready = 4'b1000; in_sel = 2'd3; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = 32'(i);
         #1 chk("stream_ready", 64'(in_ready), 64'h1);
         step();
      end
      in_valid = 1'b0;
      step(); step();
      chk("stream_count", 64'(d_seen.size()), 64'd8);
      if (d_seen.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk("stream_word", 64'(d_seen[i]), 64'(i));
            if (i > 0) chk("stream_gap", 64'(d_cyc[i] - d_cyc[i-1]), 64'd1);
         end
      end
      out_ready = 4'b0000;

      // Asynchronous reset with B and D full
      in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h11;
      step();
      in_sel = 2'd3; in_data = 32'h33;
      step();
      in_valid = 1'b0;
      chk("pre_rst_valid", 64'(out_valid), 64'hA);
      #2 RST = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'h0);
      chk("arst_out_b", 64'(out_b), 64'h0);
      chk("arst_out_d", 64'(out_d), 64'h0);
      chk("arst_busy", 64'(busy), 64'h0);
      step();
      RST = 1'b1;
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1 chk("arst_in_ready", 64'(in_ready), 64'h1);
      end

`ifdef DATA_DISTRIBUTOR_COUNT_EN
      // 65537 drains on B to exercise counter wrap
      in_sel = 2'd1; in_data = 32'h5; in_valid = 1'b1; out_ready = 4'b0010;
      for (int i = 0; i < 65537; i++) step();
      in_valid = 1'b0;
      step();
      out_ready = 4'b0000;
      chk("cnt_a", 64'(drain_count[15:0]), 64'h0);
      chk("cnt_b", 64'(drain_count[31:16]), 64'h1);
      chk("cnt_c", 64'(drain_count[47:32]), 64'h0);
      chk("cnt_d", 64'(drain_count[63:48]), 64'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_distributor_1to4.md
# data_distributor_1to4

Registered 1-to-4 data distributor for the multicycle CPU datapath: accepts one 32-bit word per handshake together with a 2-bit destination select and delivers it to exactly one of four output channels, each with its own one-entry holding register and valid/ready handshake. It is the fan-out counterpart of the 4-to-1 data selectors, used where a single result source, such as the ALU result register or memory data register, feeds several independently stalling consumers. Throughput is one word per cycle per channel when the consumer keeps ready high.

## Interface
- `WIDTH`, default 32: data width of input and all output channels.
- `CLK` input 1: sole clock, rising edge.
- `RST` input 1: reset, asynchronous, active-low. Asserting it clears all state immediately.
- `in_valid` input 1: producer offers `in_data` and `in_sel`.
- `in_ready` output 1: block accepts this cycle. Combinational from `in_sel`, `out_valid` and `out_ready`.
- `in_sel` input 2: destination channel. 0 selects A, 1 selects B, 2 selects C, 3 selects D.
- `in_data` input WIDTH: word to deliver.
- `out_valid` output 4: bit k set means channel k holds a word.
- `out_ready` input 4: bit k set means consumer k takes the word this cycle.
- `out_a`, `out_b`, `out_c`, `out_d` output WIDTH each: channel holding registers.
- `busy` output 1: OR of `out_valid`.

## Operation
- **Per-channel state:** a one-bit full flag, exposed as `out_valid[k]`, plus a WIDTH data register.
- **Input ready:** `in_ready = ~out_valid[in_sel] | out_ready[in_sel]`. Channels other than `in_sel` never block the input.
- **Accept:** an accept occurs when `in_valid & in_ready`. On accept, channel `in_sel` loads `in_data` and sets full at the next edge.
- **Drain:** a drain of channel k occurs when `out_valid[k] & out_ready[k]`. On drain without a same-cycle accept into k, full[k] clears at the next edge. The data register holds its last value.
- **Simultaneous accept and drain on the same channel:** the new word loads and full stays 1. There is no bubble.
- **Independence:** drains on other channels proceed in the same cycle, independent of the accept.
- **Input hold rules:**
  - `in_sel` and `in_data` are sampled only on accept.
  - While `in_valid` is high and `in_ready` is low, the producer holds `in_sel` and `in_data` stable.
  - The block does not require this. If `in_sel` changes, `in_ready` re-evaluates combinationally.
- **Ordering:** words are never duplicated, dropped, or reordered within a channel.
- **Ready dependency:** `out_ready` may depend on `out_valid`. `in_ready` depends on `out_ready`, so consumers must not derive `out_ready` from `in_ready`.

## Timing
- **Reset values:** all of `out_valid` = 0, `out_a`…`out_d` = 0, `busy` = 0.
  - `in_ready` is 1 for any `in_sel` during reset and immediately after release.
- **Reset mid-operation:** all held words are discarded, with no completion for pending words.
- **Latency:** accept in cycle N gives `out_valid[sel]` = 1 and the data visible in cycle N+1.
- **Minimum residence:** one cycle. A word accepted in N can be drained in N+1 at the earliest.
- **Full with consumer stalled:** `in_ready` = 0 for that `in_sel` only.
- **Stall recovery:** when the stalled consumer raises `out_ready`, `in_ready` rises in the same cycle.

## Configuration
- **`DATA_DISTRIBUTOR_COUNT_EN`:** when defined, the block adds:
  - output `drain_count` of 4×16 bits, packed with channel A at [15:0];
  - a per-channel counter that increments on each drain;
  - wrap-around from 16'hFFFF to 0 with no saturation;
  - counter reset to 0 by `RST`.
- **Without the macro:** the port and counters do not exist, and behaviour is otherwise identical.

## Test plan
- **Reset:** assert `RST`=0 mid-stream with channels B and D full. Required: `out_valid` = 4'b0000 and all outputs 0 immediately, with no clock edge needed. After release, `in_ready` = 1.
- **Single delivery:** `in_sel`=2, `in_data`=32'hDEADBEEF accepted in cycle N with `out_ready` = 0. Required: `out_valid` = 4'b0100 and `out_c` = DEADBEEF in N+1, and the value holds while stalled.
- **Backpressure isolation:** channel A full and stalled.
  - `in_sel`=0 gives `in_ready` = 0.
  - Switching to `in_sel`=1, data 32'h1 gives `in_ready` = 1, then `out_b` = 1 and `out_valid` = 4'b0011.
- **Streaming:** 8 back-to-back words 0..7 to channel D with `out_ready[3]`=1 continuously. Required: `in_ready` is high every cycle, and the consumer sees 0..7 in consecutive cycles 1 cycle delayed.
- **Simultaneous accept and drain:** channel A holds 32'hAA. Drain A and accept 32'hBB to A in the same cycle. Required: next cycle `out_a` = BB with `out_valid[0]` still 1, and exactly one drain of AA.
- **Drain counter (with `DATA_DISTRIBUTOR_COUNT_EN`):** 65537 drains on channel B. Required: count B = 1, with A, C and D at 0.
